// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 pins, deframes
// 11-bit frames and turns Set-2 make/break codes into held key levels.
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic key_space,
  output logic key_right,
  output logic key_left,
  output logic frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_filt;
  logic          filt_q;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          fall_bit;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [TW-1:0] tcnt;
  logic          byte_valid;

  logic          ext;
  logic          brk;

  // Both chains idle high, matching the bus idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The filtered level flips only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_filt <= 1'b1;
      filt_q   <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
      fall_bit <= 1'b1;
    end else begin
      filt_q   <= clk_filt;
      fall     <= filt_q & ~clk_filt;
      fall_bit <= data_sync[1];
      if (clk_sync[1] == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_sync[1];
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // byte_valid and frame_err are single-cycle pulses with no back-pressure:
  // the consumer must take shreg in the cycle byte_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      tcnt       <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (state == IDLE) begin
        tcnt <= '0;
        if (fall && !fall_bit) begin
          state   <= DATA;
          bit_cnt <= '0;
          tcnt    <= TW'(1);
        end
      end else if (fall) begin
        // The strobe cycle itself counts as the first cycle of the timeout.
        tcnt <= TW'(1);
        case (state)
          DATA: begin
            shreg   <= {fall_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= fall_bit;
            state <= STOP;
          end
          STOP: begin
            if (fall_bit && (^{shreg, par})) byte_valid <= 1'b1;
            else                            frame_err  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
        frame_err <= 1'b1;
        tcnt      <= '0;
        state     <= IDLE;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext       <= 1'b0;
      brk       <= 1'b0;
      key_space <= 1'b0;
      key_right <= 1'b0;
      key_left  <= 1'b0;
    end else if (frame_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_valid) begin
      case (shreg)
        8'hE0: ext <= 1'b1;
        8'hF0: brk <= 1'b1;
        default: begin
          if (shreg == 8'h29 && !ext) key_space <= !brk;
          if (shreg == 8'h74 &&  ext) key_right <= !brk;
          if (shreg == 8'h6B &&  ext) key_left  <= !brk;
          ext <= 1'b0;
          brk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: drives PS/2 frames on the raw pins and checks key
// levels, frame_err pulses and latencies against a byte-level model.
module tb_ps2_key_decoder;

  localparam int FL   = 8;
  localparam int TO   = 1000;
  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst;
  logic ps2c;
  logic ps2d;
  logic key_space, key_right, key_left, frame_err;

  int tests_run    = 0;
  int tests_failed = 0;

  int cyc = 0;
  int fall_cyc = 0;
  int space_chg_cyc = 0;
  int err_cyc = 0;
  int err_cnt = 0;
  int exp_err = 0;
  logic prev_space = 1'b0;

  logic m_space = 1'b0, m_right = 1'b0, m_left = 1'b0, m_ext = 1'b0, m_brk = 1'b0;
  logic [2:0] exp_q[$];

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2c), .ps2_data(ps2d),
    .key_space(key_space), .key_right(key_right), .key_left(key_left),
    .frame_err(frame_err)
  );

  // clock / reset block and monitors
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (frame_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (key_space !== prev_space) begin
      space_chg_cyc = cyc;
      prev_space = key_space;
    end
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // reference model: byte-level Set-2 interpretation
  task automatic model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 1'b0; m_brk = 1'b0; exp_err++;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (b == 8'h29 && !m_ext) m_space = !m_brk;
      if (b == 8'h74 &&  m_ext) m_right = !m_brk;
      if (b == 8'h6B &&  m_ext) m_left  = !m_brk;
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_space = 1'b0; m_right = 1'b0; m_left = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
  endtask

  // driver tasks
  task automatic drive_bit(input logic b);
    ps2d = b;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^b) ^ bad_par;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(p);
    drive_bit(!bad_stop);
    ps2d = 1'b1;
    repeat (3 * HALF) @(negedge clk);
    model_frame(b, !(bad_par || bad_stop));
  endtask

  task automatic test_reset();
    rst = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({key_space, key_right, key_left, frame_err} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b want 0000", {key_space, key_right, key_left, frame_err});
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_space();
    int base;
    base = err_cnt;
    send_frame(8'h29, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL space_make: got %b want 001", {key_left, key_right, key_space});
    end
    tests_run++;
    if (space_chg_cyc - fall_cyc !== FL + 5) begin
      tests_failed++;
      $display("[TB] FAIL space_latency: got %0d want %0d", space_chg_cyc - fall_cyc, FL + 5);
    end
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL space_break: got %b want 000", {key_left, key_right, key_space});
    end
    tests_run++;
    if (err_cnt !== base) begin
      tests_failed++;
      $display("[TB] FAIL space_no_err: got %0d want %0d", err_cnt, base);
    end
  endtask

  task automatic test_arrows();
    int base;
    base = err_cnt;
    send_frame(8'hE0, 0, 0); send_frame(8'h74, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b010) begin
      tests_failed++;
      $display("[TB] FAIL right_make: got %b want 010", {key_left, key_right, key_space});
    end
    send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b110) begin
      tests_failed++;
      $display("[TB] FAIL left_make: got %b want 110", {key_left, key_right, key_space});
    end
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h74, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL right_break: got %b want 100", {key_left, key_right, key_space});
    end
    send_frame(8'h74, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b100 || err_cnt !== base) begin
      tests_failed++;
      $display("[TB] FAIL plain_74: got keys %b errs %0d want 100 errs %0d",
               {key_left, key_right, key_space}, err_cnt, base);
    end
  endtask

  task automatic test_parity();
    int base;
    base = err_cnt;
    send_frame(8'h29, 1, 0);
    tests_run++;
    if (err_cnt !== base + 1 || key_space !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL parity_err: got errs %0d space %b want errs %0d space 0",
               err_cnt - base, key_space, 1);
    end
    tests_run++;
    if (err_cyc - fall_cyc !== FL + 4) begin
      tests_failed++;
      $display("[TB] FAIL parity_err_latency: got %0d want %0d", err_cyc - fall_cyc, FL + 4);
    end
    send_frame(8'h29, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL parity_recover: got %b want 101", {key_left, key_right, key_space});
    end
  endtask

  task automatic test_prefix_flush();
    int base;
    send_frame(8'hF0, 0, 0); send_frame(8'h29, 0, 0);
    base = err_cnt;
    send_frame(8'hF0, 0, 0);
    send_frame(8'h29, 0, 1);
    send_frame(8'h29, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b101 || err_cnt !== base + 1) begin
      tests_failed++;
      $display("[TB] FAIL prefix_flush: got keys %b errs %0d want 101 errs %0d",
               {key_left, key_right, key_space}, err_cnt, base + 1);
    end
  endtask

  task automatic test_timeout_glitch();
    int base;
    logic [7:0] b;
    b = 8'h29;
    send_frame(8'hF0, 0, 0); send_frame(8'h29, 0, 0);
    send_frame(8'hF0, 0, 0);
    base = err_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    ps2d = 1'b1;
    repeat (TO + 50) @(negedge clk);
    model_frame(8'h00, 0);
    tests_run++;
    if (err_cnt !== base + 1) begin
      tests_failed++;
      $display("[TB] FAIL timeout_err: got %0d pulses want 1", err_cnt - base);
    end
    tests_run++;
    if (err_cyc - fall_cyc !== FL + 3 + TO) begin
      tests_failed++;
      $display("[TB] FAIL timeout_latency: got %0d want %0d", err_cyc - fall_cyc, FL + 3 + TO);
    end
    send_frame(8'h29, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL timeout_recover: got %b want 101", {key_left, key_right, key_space});
    end
    base = err_cnt;
    ps2d = 1'b0;
    repeat (2) @(negedge clk);
    ps2c = 1'b0;
    repeat (5) @(negedge clk);
    ps2c = 1'b1;
    repeat (2) @(negedge clk);
    ps2d = 1'b1;
    repeat (TO + 50) @(negedge clk);
    send_frame(8'hF0, 0, 0); send_frame(8'h29, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b100 || err_cnt !== base) begin
      tests_failed++;
      $display("[TB] FAIL glitch_reject: got keys %b errs %0d want 100 errs 0",
               {key_left, key_right, key_space}, err_cnt - base);
    end
  endtask

  task automatic test_reset_mid_frame();
    int base;
    base = err_cnt;
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b1);
    ps2d = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({key_space, key_right, key_left, frame_err} !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid: got %b want 0000", {key_space, key_right, key_left, frame_err});
    end
    ps2c = 1'b1; ps2d = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (TO + 50) @(negedge clk);
    send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);
    tests_run++;
    if ({key_left, key_right, key_space} !== 3'b100 || err_cnt !== base) begin
      tests_failed++;
      $display("[TB] FAIL reset_recover: got keys %b errs %0d want 100 errs 0",
               {key_left, key_right, key_space}, err_cnt - base);
    end
  endtask

  task automatic test_random();
    logic [7:0] codes[5];
    logic [7:0] b;
    logic [2:0] exp;
    bit bad;
    codes = '{8'hE0, 8'hF0, 8'h29, 8'h74, 8'h6B};
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 5) == 5) b = 8'($urandom_range(0, 255));
      else                           b = codes[$urandom_range(0, 4)];
      bad = ($urandom_range(0, 7) == 0);
      if (bad && $urandom_range(0, 1) == 1) send_frame(b, 0, 1);
      else                                  send_frame(b, bad, 0);
      exp_q.push_back({m_left, m_right, m_space});
      exp = exp_q.pop_front();
      tests_run++;
      if ({key_left, key_right, key_space} !== exp) begin
        tests_failed++;
        $display("[TB] FAIL random_keys[%0d] byte %h: got %b want %b",
                 n, b, {key_left, key_right, key_space}, exp);
      end
    end
    tests_run++;
    if (err_cnt !== exp_err) begin
      tests_failed++;
      $display("[TB] FAIL err_count: got %0d want %0d", err_cnt, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_space();
    test_arrows();
    test_parity();
    test_prefix_flush();
    test_timeout_glitch();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
